shift_mix_columns: RTL
======================

Name: shift_mix_columns

Overview:
- Round stage directly downstream of the byte-substitution stage in the HEA AES datapath.
- Consumes the 128-bit substituted state and applies ShiftRows, then MixColumns. In the final round (last_round=1) it applies ShiftRows only.
- Uses the same start/done handshake as its neighbours. MixColumns is computed COLS_PER_CYCLE columns per clock to trade area for latency.
- Output feeds the add-round-key stage.

Parameters:
- WIDTH, 128, state width in bits; only 128 is legal.
- COLS_PER_CYCLE, 1, columns mixed per clock; legal values 1, 2, 4. Any other value is an elaboration error.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- b  input  WIDTH  substituted state. Byte k = b[8k+7:8k] is state s[r,c] with r=k%4, c=k/4.
- last_round  input  1  1 = skip MixColumns; sampled together with start
- start  input  1  request; sampled only in IDLE
- b_out  output  WIDTH  result, same byte layout as b; held until the next done
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse; b_out is valid while done is high and afterwards

Behaviour:
- Reset (async, any state): state=IDLE, column counter=0, work register=0, last_round flag=0, b_out=0, done=0, busy=0.
- States: IDLE, RUN, DONE. Encoding is free; unreachable encodings go to IDLE.
- IDLE:
  - done<=0.
  - On start=1 at edge E: work register <= ShiftRows(b), i.e. work s[r,c] = b s[r,(c+r) mod 4]. The flag latches last_round. Counter<=0. Go to RUN.
  - start=0: remain in IDLE.
- RUN:
  - Each edge replaces columns counter .. counter+COLS_PER_CYCLE-1 of the work register with MixColumns(column) if the flag is 0, or leaves them unchanged if the flag is 1.
  - Counter += COLS_PER_CYCLE.
  - After the edge that processes column 3, go to DONE.
  - RUN lasts N = 4/COLS_PER_CYCLE edges. last_round does not shorten RUN, so latency is constant.
- MixColumns per column (a0..a3 = rows 0..3), GF(2^8) with xtime(x) = (x<<1) ^ (x[7] ? 0x1b : 0):
  - o0 = 2a0^3a1^a2^a3
  - o1 = a0^2a1^3a2^a3
  - o2 = a0^a1^2a2^3a3
  - o3 = 3a0^a1^a2^2a3
  - where 2x = xtime(x) and 3x = xtime(x)^x. Purely combinational, 8-bit results, no carries beyond bit 7.
- DONE: b_out <= work register, done <= 1, go to IDLE.
- Timing:
  - With start accepted at edge E, done=1 and the new b_out are visible after edge E+N+1, for exactly one cycle.
  - Default latency is 5 edges.
- busy: 1 from the edge after start acceptance through the cycle in which done rises; 0 otherwise.
- start while not in IDLE (RUN or DONE state) is ignored and not queued. Inputs b and last_round are don't-care outside the accepting edge.
- Back-to-back: start held high is accepted again in the IDLE cycle in which done is high. Minimum start-to-start spacing is N+2 edges.
- Reset mid-RUN: abort, b_out=0, no done pulse. The first start after reset deassertion behaves normally.
- b_out changes only at the DONE edge or on reset.

Test Plan:
- Single column, COLS_PER_CYCLE=1, last_round=0:
  - b column 0 = 0x455313db, other columns constructed so that ShiftRows leaves column 0 as {db,13,53,45}.
  - Required: b_out[31:0]=0xbca14d8e. done pulses exactly 5 edges after start, one cycle wide, with busy high for 5 cycles.
- Known MixColumns columns, with ShiftRows precompensated:
  - f2 0a 22 5c -> 9f dc 58 9d
  - 01 01 01 01 -> unchanged
  - c6 c6 c6 c6 -> unchanged
  - Required: all 4 columns in one run are correct.
- ShiftRows only: last_round=1, b=0x0f0e0d0c0b0a09080706050403020100.
  - Required: b_out=0x0b06010c07020d08030e09040f0a0500, with latency still 5.
- Handshake:
  - Pulse start again during RUN and during DONE -> ignored, exactly one done.
  - Hold start high continuously -> done pulses every 6 edges, each with that run's result.
- Reset at edge 3 of RUN:
  - Required: b_out=0, done=0, busy=0 immediately (asynchronous).
  - A subsequent start produces a correct result after 5 edges.
- Sweep COLS_PER_CYCLE=2 and 4 with 100 random states:
  - Required: results match the reference model, with latency 3 and 2 edges respectively.

Source files
------------

// File: rtl/shift_mix_columns.sv
// AES round stage: ShiftRows on entry, then MixColumns over COLS_PER_CYCLE columns per clock.
// The final round skips MixColumns but keeps the same latency.
module shift_mix_columns #(
   parameter int unsigned WIDTH          = 128,
   parameter int unsigned COLS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] b,
   input  logic             last_round,
   input  logic             start,
   output logic [WIDTH-1:0] b_out,
   output logic             busy,
   output logic             done
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // A step of 4 wraps the 2-bit counter to 0, which is harmless since RUN then lasts one edge.
   localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
   localparam logic [1:0] CNT_SPAN = 2'(COLS_PER_CYCLE - 1);

   if (WIDTH != 128) begin : g_bad_width
      $error("shift_mix_columns: WIDTH must be 128");
   end
   if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
      $error("shift_mix_columns: COLS_PER_CYCLE must be 1, 2 or 4");
   end

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   // One MixColumns column; row r lives in bits [8r+7:8r].
   function automatic logic [31:0] mix_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3, o0, o1, o2, o3;
      a0 = c[7:0];
      a1 = c[15:8];
      a2 = c[23:16];
      a3 = c[31:24];
      o0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      return {o3, o2, o1, o0};
   endfunction

   function automatic logic [127:0] shift_rows(input logic [127:0] x);
      logic [127:0] s;
      s = '0;
      for (int unsigned c = 0; c < 4; c++) begin
         for (int unsigned r = 0; r < 4; r++) begin
            s[32*c + 8*r +: 8] = x[32*((c + r) % 4) + 8*r +: 8];
         end
      end
      return s;
   endfunction

   logic [1:0]   state_q, state_d;
   logic [1:0]   cnt_q, cnt_d;
   logic [127:0] work_q, work_d;
   logic         last_q, last_d;
   logic [127:0] b_out_q, b_out_d;
   logic         done_q, done_d;
   logic         busy_q, busy_d;
   logic [1:0]   col_idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         work_q  <= '0;
         last_q  <= 1'b0;
         b_out_q <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         work_q  <= work_d;
         last_q  <= last_d;
         b_out_q <= b_out_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      work_d  = work_q;
      last_d  = last_q;
      b_out_d = b_out_q;
      done_d  = 1'b0;
      col_idx = '0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               work_d  = shift_rows(b[127:0]);
               last_d  = last_round;
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            for (int unsigned j = 0; j < COLS_PER_CYCLE; j++) begin
               col_idx = cnt_q + 2'(j);
               if (!last_q) begin
                  work_d[32*col_idx +: 32] = mix_col(work_q[32*col_idx +: 32]);
               end
            end
            cnt_d = cnt_q + CNT_STEP;
            if (2'(cnt_q + CNT_SPAN) == 2'd3) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            b_out_d = work_q;
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d == ST_RUN) || (state_d == ST_DONE);
   end

   assign b_out = b_out_q;
   assign done  = done_q;
   assign busy  = busy_q;

endmodule
